// File: rtl/solver_job_sequencer.sv
// Command FIFO plus a one-job-at-a-time sequencer that launches jobs on a solver core and holds each result until it is consumed.
// The optional WAIT-state watchdog is enabled by defining SOLVER_JOB_TIMEOUT_EN.
module solver_job_sequencer #(
    parameter int RAW_W   = 60,
    parameter int ENC_W   = 78,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic [ENC_W-1:0] cmd_data,
    output logic             core_start,
    output logic [1:0]       core_mode,
    output logic [ENC_W-1:0] core_data,
    input  logic             core_done,
    input  logic [ENC_W-1:0] core_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ENC_W-1:0] res_data,
    output logic [1:0]       res_mode,
    output logic             res_err,
    output logic             busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;
    localparam logic [1:0] MODE_ENC = 2'd0;
    localparam logic [1:0] MODE_BAD = 2'd3;
    localparam logic [ENC_W-1:0] RAW_MASK = ~({ENC_W{1'b1}} << RAW_W);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    if (ENC_W < RAW_W) begin : g_chk_width
        $error("ENC_W must be >= RAW_W");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
        $error("DEPTH must be a power of two >= 2");
    end
    if (TIMEOUT < 1) begin : g_chk_timeout
        $error("TIMEOUT must be >= 1");
    end

    logic [ENC_W-1:0] fifo_data [DEPTH];
    logic [1:0]       fifo_mode [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic [1:0]       state;
    logic [1:0]       job_mode;
    logic [ENC_W-1:0] job_data;
    logic             full, push, pop;

    assign full      = (count == FULL_CNT);
    assign cmd_ready = ~full;
    assign pop       = (state == IDLE) && (count != '0);
    // A full FIFO that is being popped this cycle still takes the incoming word.
    assign push      = cmd_valid && (~full || pop);

    assign core_start = (state == ISSUE) && (job_mode != MODE_BAD);
    assign core_mode  = job_mode;
    assign core_data  = job_data;
    assign res_valid  = (state == HOLD);
    assign busy       = (count != '0) || (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_mode[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= cmd_data;
                fifo_mode[wr_ptr] <= cmd_mode;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef SOLVER_JOB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] timer;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            job_mode <= '0;
            job_data <= '0;
            res_data <= '0;
            res_mode <= '0;
            res_err  <= 1'b0;
`ifdef SOLVER_JOB_TIMEOUT_EN
            timer    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        job_mode <= fifo_mode[rd_ptr];
                        job_data <= fifo_data[rd_ptr];
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef SOLVER_JOB_TIMEOUT_EN
                    timer <= '0;
`endif
                    if (job_mode == MODE_BAD) begin
                        res_data <= '0;
                        res_mode <= job_mode;
                        res_err  <= 1'b1;
                        state    <= HOLD;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (core_done) begin
                        // Decrypt and regen produce plaintext, so only the low RAW_W bits are meaningful.
                        res_data <= (job_mode == MODE_ENC) ? core_result : (core_result & RAW_MASK);
                        res_mode <= job_mode;
                        res_err  <= 1'b0;
                        state    <= HOLD;
                    end
`ifdef SOLVER_JOB_TIMEOUT_EN
                    else if (timer == TW'(TIMEOUT - 1)) begin
                        res_data <= '0;
                        res_mode <= job_mode;
                        res_err  <= 1'b1;
                        state    <= HOLD;
                    end else begin
                        timer <= timer + 1'b1;
                    end
`endif
                end
                default: begin
                    if (res_ready)
                        state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_solver_job_sequencer.sv
// Directed bench for solver_job_sequencer: a reactive core model plus a result scoreboard.
// The timeout scenario runs only when SOLVER_JOB_TIMEOUT_EN is defined.
module tb_solver_job_sequencer;
    localparam int RAW_W   = 60;
    localparam int ENC_W   = 78;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 32;
    typedef logic [ENC_W-1:0] word_t;
    typedef struct packed { word_t data; logic [1:0] mode; logic err; } res_t;
    localparam word_t RAW_MASK = ~({ENC_W{1'b1}} << RAW_W);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cmd_valid, cmd_ready, core_start, core_done, res_valid, res_ready, res_err, busy;
    logic [1:0] cmd_mode, core_mode, res_mode;
    word_t cmd_data, core_data, core_result, res_data;

    res_t  exp_q[$];
    word_t plan_q[$];
    int    checks = 0;
    int    failures = 0;
    int    start_cnt = 0;
    int    core_lat = 0;
    bit    stall = 1'b0;
    bit    pend = 1'b0;
    int    cnt = 0;
    logic  model_done = 1'b0;
    logic  inj_done = 1'b0;
    word_t model_res = '0;
    word_t inj_res = '0;
    word_t last_start_data = '0;
    logic [1:0] last_start_mode = '0;

    assign core_done   = model_done | inj_done;
    assign core_result = inj_done ? inj_res : model_res;

    solver_job_sequencer #(.RAW_W(RAW_W), .ENC_W(ENC_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .cmd_data(cmd_data), .core_start(core_start), .core_mode(core_mode), .core_data(core_data),
        .core_done(core_done), .core_result(core_result), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_mode(res_mode), .res_err(res_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Core model: answers each launch after core_lat cycles with the next planned result.
    initial begin
        forever begin
            @(negedge clk);
            model_done = 1'b0;
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    if (cnt == 0 && !stall) begin
                        model_done = 1'b1;
                        model_res  = (plan_q.size() != 0) ? plan_q.pop_front() : '0;
                        pend       = 1'b0;
                    end else if (cnt != 0) begin
                        cnt--;
                    end
                end
                if (core_start === 1'b1) begin
                    pend = 1'b1;
                    cnt  = core_lat;
                    start_cnt++;
                    last_start_mode = core_mode;
                    last_start_data = core_data;
                end
            end
        end
    end

    task automatic chk(input string tag, input word_t obs, input word_t expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic send(input logic [1:0] m, input word_t d);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        chk("send_ready", word_t'(cmd_ready), word_t'(1));
        cmd_valid = 1'b1;
        cmd_mode  = m;
        cmd_data  = d;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic job(input logic [1:0] m, input word_t d, input word_t plan);
        res_t e;
        if (m == 2'd3) begin
            e = '{data: '0, mode: m, err: 1'b1};
        end else begin
            plan_q.push_back(plan);
            e = '{data: (m == 2'd0) ? plan : (plan & RAW_MASK), mode: m, err: 1'b0};
        end
        exp_q.push_back(e);
        send(m, d);
    endtask

    task automatic get_result(input string tag, input int limit, output int n);
        res_t e;
        n = 0;
        while (res_valid !== 1'b1 && n < limit) begin @(negedge clk); n++; end
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        chk({tag, "_valid"}, word_t'(res_valid), word_t'(1));
        chk({tag, "_data"}, res_data, e.data);
        chk({tag, "_mode"}, word_t'(res_mode), word_t'(e.mode));
        chk({tag, "_err"}, word_t'(res_err), word_t'(e.err));
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, word_t'(cmd_ready), word_t'(1));
        chk({tag, "_core_start"}, word_t'(core_start), '0);
        chk({tag, "_core_mode"}, word_t'(core_mode), '0);
        chk({tag, "_core_data"}, core_data, '0);
        chk({tag, "_res_valid"}, word_t'(res_valid), '0);
        chk({tag, "_res_data"}, res_data, '0);
        chk({tag, "_res_mode"}, word_t'(res_mode), '0);
        chk({tag, "_res_err"}, word_t'(res_err), '0);
        chk({tag, "_busy"}, word_t'(busy), '0);
    endtask

    initial begin
        int n, s0, seen;
        res_t e;
        cmd_valid = 1'b0; cmd_mode = '0; cmd_data = '0; res_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("rst0");
        rst = 1'b0;
        @(negedge clk);

        // Stray core_done while idle must not produce anything.
        inj_res = '1; inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_done_valid", word_t'(res_valid), '0);
        chk("idle_done_busy", word_t'(busy), '0);

        core_lat = 5;
        job(2'd0, 78'h0123456789ABCDE, 78'h3A5);
        get_result("enc", 40, n);
        chk("enc_starts", word_t'(start_cnt), word_t'(1));
        chk("enc_core_mode", word_t'(last_start_mode), '0);
        chk("enc_core_data", last_start_data, 78'h0123456789ABCDE);

        core_lat = 2;
        job(2'd1, 78'h12345, 78'h3FFFFFFFFFFFFFFFFFFF);
        get_result("dec", 40, n);
        chk("dec_core_mode", word_t'(last_start_mode), word_t'(1));

        core_lat = 0;
        job(2'd2, 78'h7, 78'h2AAAAAAAAAAAAAAAAAAA);
        get_result("regen", 40, n);
        chk("regen_latency", word_t'(n), word_t'(3));

        s0 = start_cnt;
        job(2'd3, 78'h55, '0);
        get_result("illegal", 40, n);
        chk("illegal_within3", word_t'(n <= 3), word_t'(1));
        chk("illegal_no_start", word_t'(start_cnt), word_t'(s0));

        // Backpressure: result held, late strobe ignored, second job not launched.
        core_lat = 1;
        s0 = start_cnt;
        job(2'd0, 78'h1111, 78'h3123456789ABCDEF0123);
        job(2'd1, 78'h2222, 78'h0FEDCBA9876543210FED);
        n = 0;
        while (res_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        e = exp_q[0];
        for (int i = 0; i < 10; i++) begin
            inj_res  = 78'h1234;
            inj_done = (i == 3);
            @(negedge clk);
            chk("bp_valid", word_t'(res_valid), word_t'(1));
            chk("bp_data", res_data, e.data);
            chk("bp_err", word_t'(res_err), word_t'(e.err));
            chk("bp_no_launch", word_t'(start_cnt), word_t'(s0 + 1));
        end
        inj_done = 1'b0;
        get_result("bp0", 40, n);
        get_result("bp1", 40, n);

        // Fill: core stalled, five back-to-back commands.
        stall = 1'b1;
        core_lat = 0;
        s0 = start_cnt;
        for (int i = 0; i < 5; i++)
            job(2'(i % 3), word_t'(i + 16), word_t'(78'h3C0000000000000000A0 + i));
        chk("fill_ready_low", word_t'(cmd_ready), '0);
        chk("fill_busy", word_t'(busy), word_t'(1));
        chk("fill_one_start", word_t'(start_cnt), word_t'(s0 + 1));
        stall = 1'b0;
        for (int i = 0; i < 5; i++)
            get_result("fill", 40, n);
        chk("fill_starts", word_t'(start_cnt), word_t'(s0 + 5));

`ifdef SOLVER_JOB_TIMEOUT_EN
        stall = 1'b1;
        plan_q.push_back(78'h77);
        exp_q.push_back('{data: '0, mode: 2'd0, err: 1'b1});
        send(2'd0, 78'h99);
        get_result("tmo", 60, n);
        chk("tmo_cycles", word_t'(n), word_t'(TIMEOUT + 2));
        stall = 1'b0;
        repeat (4) @(negedge clk);
        chk("tmo_late_valid", word_t'(res_valid), '0);
        chk("tmo_late_busy", word_t'(busy), '0);
`endif

        // Reset mid-WAIT with two jobs queued.
        stall = 1'b1;
        job(2'd0, 78'hA, 78'h1);
        job(2'd1, 78'hB, 78'h2);
        job(2'd2, 78'hC, 78'h3);
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", word_t'(busy), word_t'(1));
        #2 rst = 1'b1;
        #1 chk_reset_outputs("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        plan_q.delete();
        stall = 1'b0;
        s0 = start_cnt;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (res_valid !== 1'b0) seen++;
        end
        chk("post_rst_no_result", word_t'(seen), '0);
        chk("post_rst_no_start", word_t'(start_cnt), word_t'(s0));
        chk("post_rst_busy", word_t'(busy), '0);

        job(2'd2, 78'hD, 78'h3FFFFFFFFFFFFFFFF00F);
        get_result("recover", 40, n);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/solver_job_sequencer.md
SOLVER_JOB_SEQUENCER -- requirements
Module: solver_job_sequencer

Interface
REQ-001 SHALL have parameter RAW_W, default 60, plaintext width.
REQ-002 SHALL have parameter ENC_W, default 78, ciphertext width; ENC_W >= RAW_W.
REQ-003 SHALL have parameter DEPTH, default 4, command FIFO entries; power of two, >= 2.
REQ-004 SHALL have parameter TIMEOUT, default 32, maximum core cycles per job.
REQ-005 Clk  in  1  single clock; all state on rising edge.
REQ-006 Rst  in  1  reset; asynchronous, active-high.
REQ-007 cmd_valid  in  1  command offered.
REQ-008 cmd_ready  out  1  FIFO not full.
REQ-009 cmd_mode  in  2  0 encrypt, 1 decrypt, 2 password regen, 3 illegal.
REQ-010 cmd_data  in  ENC_W  payload; encrypt uses bits [RAW_W-1:0].
REQ-011 core_start  out  1  one-cycle job launch pulse.
REQ-012 core_mode  out  2  mode of launched job, held until core_done.
REQ-013 core_data  out  ENC_W  payload of launched job, held until core_done.
REQ-014 core_done  in  1  core result strobe.
REQ-015 core_result  in  ENC_W  core result; valid with core_done.
REQ-016 res_valid  out  1  result available.
REQ-017 res_ready  in  1  consumer accepts result.
REQ-018 res_data  out  ENC_W  result; decrypt/regen zero-extended above RAW_W.
REQ-019 res_mode  out  2  mode of job producing result.
REQ-020 res_err  out  1  job failed (illegal mode or timeout).
REQ-021 busy  out  1  FIFO non-empty or FSM not IDLE.

Function
REQ-022 Command accepted when cmd_valid and cmd_ready high at rising edge; written to FIFO tail.
REQ-023 FIFO full -> cmd_ready low; empty FIFO plus simultaneous push and pop impossible (pop reads registered head only).
REQ-024 Full FIFO with simultaneous pop and push: SHALL accept push; cmd_ready derived from registered count only, so stays low that cycle.
REQ-025 Pointers SHALL wrap modulo DEPTH; count range 0..DEPTH.
REQ-026 FSM states: IDLE, ISSUE, WAIT, HOLD.
REQ-027 IDLE: FIFO non-empty -> pop head, go ISSUE next cycle.
REQ-028 ISSUE: mode 0-2 -> core_start high exactly one cycle, go WAIT; mode 3 -> no core_start, load res_err=1, res_data=0, go HOLD.
REQ-029 WAIT: core_done -> register core_result (masked per REQ-018), res_err=0, go HOLD; core_start SHALL not reassert.
REQ-030 HOLD: res_valid high; res_data/res_mode/res_err stable until res_valid and res_ready; then IDLE.
REQ-031 Minimum latency pop-to-res_valid: 3 cycles with core_done on first WAIT cycle; one job in flight at a time; results in command order.
REQ-032 core_done outside WAIT SHALL be ignored.

Reset
REQ-033 Rst high SHALL immediately clear FIFO, pointers, count, timer and FSM to IDLE regardless of Clk.
REQ-034 Reset values: cmd_ready=1, core_start=0, core_mode=0, core_data=0, res_valid=0, res_data=0, res_mode=0, res_err=0, busy=0.
REQ-035 Reset mid-job SHALL discard in-flight and queued jobs; no result emitted.

Configuration
REQ-036 Macro SOLVER_JOB_TIMEOUT_EN: defined -> cycle counter runs in WAIT, cleared on entry; reaching TIMEOUT without core_done -> res_err=1, res_data=0, go HOLD.
REQ-037 SOLVER_JOB_TIMEOUT_EN undefined -> no counter; WAIT persists until core_done; TIMEOUT unused.

Verification
REQ-038 Encrypt: cmd mode 0, data 60'h0123456789ABCDE, core_done after 5 cycles with 78'h3A5 -> one core_start, res_valid res_data=78'h3A5 res_mode=0 res_err=0.
REQ-039 Fill: 5 commands back-to-back, DEPTH=4, core stalled -> cmd_ready low after 4th FIFO entry plus 1 in flight; results emerge in order.
REQ-040 Illegal: cmd mode 3 -> no core_start, res_err=1, res_data=0 within 3 cycles.
REQ-041 Backpressure: res_ready low 10 cycles -> res_* stable, next job not launched until handshake.
REQ-042 Timeout (macro on, TIMEOUT=32): no core_done -> res_err=1 after 32 WAIT cycles; late core_done ignored.
REQ-043 Reset mid-WAIT with 2 queued -> all outputs reset values, no res_valid afterward, busy=0.
